// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types, timing defaults and elaboration helpers for the seven-segment scan controller.
package seg_scan_pkg;

  localparam int unsigned DEF_NUM_DIGITS   = 4;
  localparam int unsigned DEF_SCAN_DIV     = 50000;
  localparam int unsigned DEF_GUARD_CYCLES = 500;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } scan_state_e;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-word load handshake between the value producer and the scan controller.
interface seg_scan_ctrl_if
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic [NUM_DIGITS-1:0]   load_dp;

  modport master (output load_valid, output load_value, output load_dp, input load_ready);
  modport slave  (input load_valid, input load_value, input load_dp, output load_ready);
endinterface

// File: rtl/seg_scan_ctrl_lz.sv
// Leading-zero blanking mask: digit k blanks when it and every more significant nibble are zero.
module seg_lz_mask
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS
) (
  input  logic [4*NUM_DIGITS-1:0] word,
  input  logic                    blank_en,
  output logic [NUM_DIGITS-1:0]   lz_c
);

  logic zero_run;

  // Walk from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    lz_c     = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run = zero_run & (word[4*k +: 4] == 4'h0);
      lz_c[k]  = blank_en & zero_run;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with double-buffered display word
// and an all-off guard interval between digits.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int unsigned SCAN_DIV     = DEF_SCAN_DIV,
  parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  disp_en,
  input  logic                  lz_blank_en,
  seg_scan_ctrl_if.slave        ld,
  output logic [3:0]            hex_out,
  output logic                  seg_blank,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_done
);

  localparam int unsigned CNT_W  = clog2(max2(SCAN_DIV, GUARD_CYCLES));
  localparam int unsigned IDX_W  = clog2(NUM_DIGITS);
  localparam int unsigned WORD_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e           state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [WORD_W-1:0]     active;
  logic [NUM_DIGITS-1:0] active_dp;
  logic [WORD_W-1:0]     pend;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] lz_c;
  logic                  slot_end;
  logic                  frame_end;

  seg_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz (
    .word     (active),
    .blank_en (lz_blank_en),
    .lz_c     (lz_c)
  );

  assign slot_end  = (state == ST_ON) ? (cnt == ON_LAST) : (cnt == GUARD_LAST);
  assign frame_end = disp_en && (state == ST_ON) && slot_end && (idx == IDX_LAST);

  // load_ready doubles as the pending-empty flag; transfers only at frame ends or while dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld.load_ready <= 1'b1;
      pend          <= '0;
      pend_dp       <= '0;
      active        <= '0;
      active_dp     <= '0;
    end else if (ld.load_valid && ld.load_ready) begin
      pend          <= ld.load_value;
      pend_dp       <= ld.load_dp;
      ld.load_ready <= 1'b0;
    end else if (!ld.load_ready && (frame_end || !disp_en)) begin
      active        <= pend;
      active_dp     <= pend_dp;
      ld.load_ready <= 1'b1;
    end
  end

  // Scan FSM: GUARD (all dark) alternates with ON (one digit lit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_GUARD;
      cnt        <= '0;
      idx        <= '0;
      digit_en   <= '0;
      hex_out    <= '0;
      seg_blank  <= 1'b1;
      dp_out     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!disp_en) begin
        state     <= ST_GUARD;
        cnt       <= '0;
        idx       <= '0;
        digit_en  <= '0;
        seg_blank <= 1'b1;
        dp_out    <= 1'b0;
      end else if (!slot_end) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
        if (state == ST_GUARD) begin
          state     <= ST_ON;
          digit_en  <= NUM_DIGITS'(1) << idx;
          hex_out   <= active[{idx, 2'b00} +: 4];
          dp_out    <= active_dp[idx];
          seg_blank <= lz_c[idx];
        end else begin
          state     <= ST_GUARD;
          digit_en  <= '0;
          seg_blank <= 1'b1;
          dp_out    <= 1'b0;
          if (idx == IDX_LAST) begin
            idx        <= '0;
            frame_done <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position model queues the expected outputs
// for every cycle and a negedge monitor compares them against the DUT.
module tb_seg_scan_ctrl;
  import seg_scan_pkg::*;

  localparam int unsigned ND    = 4;
  localparam int unsigned SD    = 4;
  localparam int unsigned GC    = 2;
  localparam int unsigned SLOT  = SD + GC;
  localparam int unsigned FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_en;
  logic          lz_blank_en;
  logic [3:0]    hex_out;
  logic          seg_blank;
  logic          dp_out;
  logic [ND-1:0] digit_en;
  logic          frame_done;

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) ld ();

  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD_CYCLES(GC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_en     (disp_en),
    .lz_blank_en (lz_blank_en),
    .ld          (ld),
    .hex_out     (hex_out),
    .seg_blank   (seg_blank),
    .dp_out      (dp_out),
    .digit_en    (digit_en),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ND-1:0] den;
    logic [3:0]    hex;
    logic          dp;
    logic          blank;
    logic          fd;
    logic          rdy;
    logic          on;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  int            m_pos;
  logic [4*ND-1:0] m_act, m_pend;
  logic [ND-1:0] m_act_dp, m_pend_dp;
  logic          m_full, m_fd, m_rst, m_acc, m_xfer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Expected outputs for the cycle at frame position m_pos.
  function automatic exp_t expect_now();
    exp_t e;
    int   d, w;
    d       = m_pos / SLOT;
    w       = m_pos % SLOT;
    e.on    = (w >= GC);
    e.den   = e.on ? (ND'(1) << d) : '0;
    e.hex   = 4'(m_act >> (4 * d));
    e.dp    = m_act_dp[d];
    e.blank = e.on ? (lz_blank_en && d != 0 && (m_act >> (4 * d)) == '0) : 1'b1;
    e.fd    = m_fd;
    e.rdy   = !m_full;
    return e;
  endfunction

  always @(posedge clk) begin
    m_rst = rst_n;
    if (!rst_n) begin
      m_pos = 0; m_act = '0; m_act_dp = '0; m_pend = '0; m_pend_dp = '0;
      m_full = 1'b0; m_fd = 1'b0;
    end else begin
      m_acc = ld.load_valid && !m_full;
      if (!disp_en) begin
        m_xfer = m_full;
        m_pos  = 0;
        m_fd   = 1'b0;
      end else begin
        m_xfer = m_full && (m_pos == FRAME - 1);
        m_fd   = (m_pos == FRAME - 1);
        m_pos  = (m_pos + 1) % FRAME;
      end
      if (m_xfer) begin
        m_act = m_pend; m_act_dp = m_pend_dp; m_full = 1'b0;
      end
      if (m_acc) begin
        m_pend = ld.load_value; m_pend_dp = ld.load_dp; m_full = 1'b1;
      end
    end
    sb_q.push_back(expect_now());
  end

  // Skip a cycle whose reset level changed after the model sampled it.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      if (rst_n === m_rst) begin
        check("digit_en", 32'(digit_en), 32'(mon_e.den));
        check("seg_blank", 32'(seg_blank), 32'(mon_e.blank));
        check("frame_done", 32'(frame_done), 32'(mon_e.fd));
        check("load_ready", 32'(ld.load_ready), 32'(mon_e.rdy));
        if (mon_e.on) begin
          check("hex_out", 32'(hex_out), 32'(mon_e.hex));
          check("dp_out", 32'(dp_out), 32'(mon_e.dp));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int p);
    for (int i = 0; i < 2 * FRAME && m_pos != p; i++) tick(1);
  endtask

  task automatic load(input logic [4*ND-1:0] v, input logic [ND-1:0] dp);
    ld.load_valid = 1'b1;
    ld.load_value = v;
    ld.load_dp    = dp;
    tick(1);
    ld.load_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    disp_en       = 1'b1;
    lz_blank_en   = 1'b0;
    ld.load_valid = 1'b0;
    ld.load_value = '0;
    ld.load_dp    = '0;
    tick(3);
    #1 rst_n = 1'b1;
    tick(2 * FRAME);

    wait_pos(8);
    load(16'h1234, 4'b0100);
    tick(2 * FRAME);

    wait_pos(3);
    load(16'h1111, 4'b0000);
    ld.load_valid = 1'b1;
    ld.load_value = 16'h2222;
    ld.load_dp    = 4'b0001;
    tick(FRAME);
    ld.load_valid = 1'b0;
    tick(2 * FRAME);

    disp_en     = 1'b0;
    lz_blank_en = 1'b1;
    tick(1);
    load(16'h0040, 4'b1000);
    tick(2);
    disp_en = 1'b1;
    tick(FRAME + 3);
    disp_en = 1'b0;
    tick(1);
    load(16'h0000, 4'b0010);
    tick(2);
    disp_en = 1'b1;
    tick(FRAME + 3);

    wait_pos(2 * SLOT + GC);
    load(16'h5678, 4'b0011);
    disp_en = 1'b0;
    tick(3);
    disp_en = 1'b1;
    tick(FRAME + 2);

    wait_pos(SLOT + GC + 1);
    load(16'h9abc, 4'b1111);
    #1 rst_n = 1'b0;
    #1;
    check("rst_digit_en", 32'(digit_en), 32'h0);
    check("rst_hex_out", 32'(hex_out), 32'h0);
    check("rst_seg_blank", 32'(seg_blank), 32'h1);
    check("rst_dp_out", 32'(dp_out), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_load_ready", 32'(ld.load_ready), 32'h1);
    tick(2);
    #1 rst_n = 1'b1;
    tick(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
